// File: rtl/ristretto_trap_sequencer.sv
// Trap sequencer: mip pending register, fixed-priority trap/interrupt selection, and an
// IDLE/ENTRY/RETURN/REDIRECT FSM issuing one CSR write per trap or MRET, then a held PC redirect.
module ristretto_trap_sequencer #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int NumIrq    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 priv_lvl_i,
  input  logic [AddrWidth-1:0] next_pc_i,
  input  logic [DataWidth-1:0] fault_instr_i,
  input  logic [AddrWidth-1:0] lsu_fault_addr_i,
  input  logic [1:0]           instr_exception_i,
  input  logic [1:0]           lsu_exception_i,
  input  logic [1:0]           env_exception_i,
  input  logic [NumIrq-1:0]    irq_i,
  input  logic [NumIrq-1:0]    irq_en_i,
  input  logic [NumIrq-1:0]    pend_clr_i,
  input  logic                 mstatus_mie_i,
  input  logic                 mstatus_mpie_i,
  input  logic [AddrWidth-1:0] mtvec_i,
  input  logic [AddrWidth-1:0] mepc_i,
  output logic [NumIrq-1:0]    irq_pending_o,
  output logic                 csr_we_o,
  output logic [DataWidth-1:0] mcause_o,
  output logic [DataWidth-1:0] mtval_o,
  output logic [AddrWidth-1:0] mepc_o,
  output logic [2:0]           trap_state_o,
  output logic                 busy_o,
  output logic                 redirect_valid_o,
  output logic [AddrWidth-1:0] redirect_addr_o,
  input  logic                 redirect_ready_i
);

  typedef enum logic [1:0] {IDLE, ENTRY, RETURN, REDIRECT} state_t;

  state_t               state, state_next;
  logic [NumIrq-1:0]    pend, eligible;
  logic                 irq_any, exc_any, take_trap, take_mret;
  logic [4:0]           irq_code, exc_code, code;
  logic [DataWidth-1:0] mtval_next, mcause_next;
  logic [AddrWidth-1:0] base, target;
  logic                 unused_mtvec;

  assign unused_mtvec  = mtvec_i[1];
  assign irq_pending_o = pend;
  assign eligible      = pend & irq_en_i & {NumIrq{mstatus_mie_i}};

  // Ascending scan lets the highest plain index win; 7, 3, 11 override in rising priority.
  always_comb begin
    irq_any  = |eligible;
    irq_code = '0;
    for (int i = 0; i < NumIrq; i++) begin
      if (eligible[i] && i != 3 && i != 7 && i != 11) irq_code = 5'(i);
    end
    if (eligible[7])  irq_code = 5'd7;
    if (eligible[3])  irq_code = 5'd3;
    if (eligible[11]) irq_code = 5'd11;
  end

  always_comb begin
    exc_any    = 1'b1;
    exc_code   = '0;
    mtval_next = '0;
    if (instr_exception_i[1]) begin
      exc_code   = 5'd2;
      mtval_next = fault_instr_i;
    end else if (instr_exception_i[0]) begin
      exc_code   = 5'd0;
      mtval_next = fault_instr_i;
    end else if (lsu_exception_i[0]) begin
      exc_code   = 5'd4;
      mtval_next = DataWidth'(lsu_fault_addr_i);
    end else if (lsu_exception_i[1]) begin
      exc_code   = 5'd6;
      mtval_next = DataWidth'(lsu_fault_addr_i);
    end else if (env_exception_i[0]) begin
      exc_code   = priv_lvl_i ? 5'd11 : 5'd8;
    end else begin
      exc_any    = 1'b0;
    end
  end

  always_comb begin
    code        = exc_any ? exc_code : irq_code;
    take_trap   = exc_any | irq_any;
    take_mret   = env_exception_i[1] & ~exc_any;
    mcause_next = '0;
    mcause_next[DataWidth-1] = ~exc_any;
    mcause_next[4:0]         = code;
    base   = {mtvec_i[AddrWidth-1:2], 2'b00};
    target = (!exc_any && mtvec_i[0]) ? base + (AddrWidth'(irq_code) << 2) : base;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_trap)      state_next = ENTRY;
        else if (take_mret) state_next = RETURN;
      end
      ENTRY, RETURN: state_next = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs are registered from the next state so each one lines up with its state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend             <= '0;
      csr_we_o         <= 1'b0;
      busy_o           <= 1'b0;
      redirect_valid_o <= 1'b0;
      mcause_o         <= '0;
      mtval_o          <= '0;
      mepc_o           <= '0;
      trap_state_o     <= '0;
      redirect_addr_o  <= '0;
    end else begin
      pend             <= (pend & ~pend_clr_i) | irq_i;
      csr_we_o         <= (state_next == ENTRY) || (state_next == RETURN);
      busy_o           <= (state_next != IDLE);
      redirect_valid_o <= (state_next == REDIRECT);
      if (state == IDLE && take_trap) begin
        mcause_o        <= mcause_next;
        mtval_o         <= mtval_next;
        mepc_o          <= next_pc_i;
        trap_state_o    <= {1'b0, mstatus_mie_i, priv_lvl_i};
        redirect_addr_o <= target;
      end else if (state == IDLE && take_mret) begin
        trap_state_o    <= {mstatus_mpie_i, 2'b11};
        redirect_addr_o <= mepc_i;
      end
    end
  end

endmodule

// File: tb/tb_ristretto_trap_sequencer.sv
// Directed bench: stimulus pushes expected CSR writes and redirects; a negedge monitor pops and compares.
module tb_ristretto_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        priv_lvl_i;
  logic [31:0] next_pc_i, fault_instr_i, lsu_fault_addr_i;
  logic [1:0]  instr_exception_i, lsu_exception_i, env_exception_i;
  logic [15:0] irq_i, irq_en_i, pend_clr_i;
  logic        mstatus_mie_i, mstatus_mpie_i;
  logic [31:0] mtvec_i, mepc_i;
  logic [15:0] irq_pending_o;
  logic        csr_we_o;
  logic [31:0] mcause_o, mtval_o, mepc_o;
  logic [2:0]  trap_state_o;
  logic        busy_o, redirect_valid_o;
  logic [31:0] redirect_addr_o;
  logic        redirect_ready_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mepc;
    logic [2:0]  ts;
  } csr_exp_t;

  csr_exp_t    csr_q[$];
  logic [31:0] redir_q[$];

  always #5 clk = ~clk;

  ristretto_trap_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .priv_lvl_i(priv_lvl_i), .next_pc_i(next_pc_i),
    .fault_instr_i(fault_instr_i), .lsu_fault_addr_i(lsu_fault_addr_i),
    .instr_exception_i(instr_exception_i), .lsu_exception_i(lsu_exception_i),
    .env_exception_i(env_exception_i), .irq_i(irq_i), .irq_en_i(irq_en_i),
    .pend_clr_i(pend_clr_i), .mstatus_mie_i(mstatus_mie_i), .mstatus_mpie_i(mstatus_mpie_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .irq_pending_o(irq_pending_o), .csr_we_o(csr_we_o),
    .mcause_o(mcause_o), .mtval_o(mtval_o), .mepc_o(mepc_o), .trap_state_o(trap_state_o),
    .busy_o(busy_o), .redirect_valid_o(redirect_valid_o), .redirect_addr_o(redirect_addr_o),
    .redirect_ready_i(redirect_ready_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_trap(input logic [31:0] mc, input logic [31:0] mt, input logic [31:0] me,
                             input logic [2:0] ts, input logic [31:0] ra);
    csr_exp_t e;
    e.mcause = mc; e.mtval = mt; e.mepc = me; e.ts = ts;
    csr_q.push_back(e);
    redir_q.push_back(ra);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the redirect, apply a pending clear, then accept it for one cycle.
  task automatic release_redirect(input logic [15:0] clr);
    int n;
    n = 0;
    while (!redirect_valid_o && n < 20) begin
      tick();
      n++;
    end
    if (!redirect_valid_o) begin
      checks++;
      errors++;
      $display("FAIL redirect_timeout: got no redirect_valid, expected one within 20 cycles");
    end else begin
      pend_clr_i = clr;
      tick();
      pend_clr_i = '0;
      redirect_ready_i = 1'b1;
      tick();
      redirect_ready_i = 1'b0;
    end
  endtask

  // Monitor
  logic        prev_we, prev_vld, prev_rdy;
  logic [31:0] prev_addr;
  always @(negedge clk) begin
    if (rst_i) begin
      prev_we  = 1'b0;
      prev_vld = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (prev_we) check("we_then_redirect", {csr_we_o, redirect_valid_o}, 2'b01);
      if (csr_we_o) begin
        if (csr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_csr_we: got csr_we_o=1 mcause=0x%0h, expected no write", mcause_o);
        end else begin
          csr_exp_t e;
          e = csr_q.pop_front();
          check("mcause", mcause_o, e.mcause);
          check("mtval", mtval_o, e.mtval);
          check("mepc", mepc_o, e.mepc);
          check("trap_state", trap_state_o, e.ts);
        end
      end
      if (redirect_valid_o && prev_vld && !prev_rdy)
        check("redirect_stable", redirect_addr_o, prev_addr);
      if (redirect_valid_o && redirect_ready_i) begin
        if (redir_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_redirect: got addr 0x%0h, expected none", redirect_addr_o);
        end else begin
          check("redirect_addr", redirect_addr_o, redir_q.pop_front());
        end
      end
      prev_we   = csr_we_o;
      prev_vld  = redirect_valid_o;
      prev_rdy  = redirect_ready_i;
      prev_addr = redirect_addr_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; priv_lvl_i = 1'b1; next_pc_i = '0; fault_instr_i = '0; lsu_fault_addr_i = '0;
    instr_exception_i = '0; lsu_exception_i = '0; env_exception_i = '0;
    irq_i = '0; irq_en_i = 16'hFFFF; pend_clr_i = '0; mstatus_mie_i = 1'b0; mstatus_mpie_i = 1'b0;
    mtvec_i = '0; mepc_i = '0; redirect_ready_i = 1'b0;
    repeat (3) tick();
    check("rst_csr_we", csr_we_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_redirect_valid", redirect_valid_o, 0);
    check("rst_pending", irq_pending_o, 0);
    check("rst_mcause", mcause_o, 0);
    rst_i = 1'b0;
    tick();

    // Vectored MEI
    mtvec_i = 32'h101; mstatus_mie_i = 1'b1; next_pc_i = 32'h2040;
    expect_trap(32'h8000000B, 32'h0, 32'h2040, 3'b011, 32'h12C);
    irq_i[11] = 1'b1;
    tick();
    irq_i = '0;
    tick();
    check("mei_we_timing", csr_we_o, 1);
    release_redirect(16'h0800);

    // Illegal instruction beats a pending MEI; MEI is taken afterwards
    mtvec_i = 32'h100; mstatus_mie_i = 1'b0; next_pc_i = 32'h1000;
    irq_i[11] = 1'b1;
    tick();
    irq_i = '0;
    tick();
    check("mei_held_masked", irq_pending_o, 16'h0800);
    expect_trap(32'h2, 32'hFFFFFFFF, 32'h1000, 3'b011, 32'h100);
    expect_trap(32'h8000000B, 32'h0, 32'h1000, 3'b011, 32'h100);
    mstatus_mie_i = 1'b1; fault_instr_i = 32'hFFFFFFFF; instr_exception_i = 2'b10;
    tick();
    instr_exception_i = '0;
    release_redirect(16'h0000);
    check("mei_still_pending", irq_pending_o[11], 1);
    release_redirect(16'h0800);

    // Simultaneous 3, 7, 15: masked first, then taken in priority order
    mtvec_i = 32'h101; mstatus_mie_i = 1'b0; next_pc_i = 32'h4000;
    irq_i = 16'h8088;
    tick();
    irq_i = '0;
    tick();
    tick();
    check("masked_pending", irq_pending_o, 16'h8088);
    check("masked_idle", busy_o, 0);
    expect_trap(32'h80000003, 32'h0, 32'h4000, 3'b011, 32'h10C);
    expect_trap(32'h80000007, 32'h0, 32'h4000, 3'b011, 32'h11C);
    expect_trap(32'h8000000F, 32'h0, 32'h4000, 3'b011, 32'h13C);
    mstatus_mie_i = 1'b1;
    release_redirect(16'h0008);
    release_redirect(16'h0080);
    release_redirect(16'h8000);
    mstatus_mie_i = 1'b0;
    check("all_cleared", irq_pending_o, 0);

    // MRET with held-off handshake; cause/tval/epc keep the last trap's values
    mepc_i = 32'h3000; mstatus_mpie_i = 1'b1;
    expect_trap(32'h8000000F, 32'h0, 32'h4000, 3'b111, 32'h3000);
    env_exception_i = 2'b10;
    tick();
    env_exception_i = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("mret_hold_valid", redirect_valid_o, 1);
      check("mret_hold_addr", redirect_addr_o, 32'h3000);
      check("mret_hold_busy", busy_o, 1);
      tick();
    end
    release_redirect(16'h0000);

    // Misaligned load in vectored mode uses the base; ECALL from U-mode
    next_pc_i = 32'h5000; lsu_fault_addr_i = 32'h7003;
    expect_trap(32'h4, 32'h7003, 32'h5000, 3'b001, 32'h100);
    lsu_exception_i = 2'b01;
    tick();
    lsu_exception_i = '0;
    release_redirect(16'h0000);
    next_pc_i = 32'h5004; priv_lvl_i = 1'b0; mstatus_mie_i = 1'b1;
    expect_trap(32'h8, 32'h0, 32'h5004, 3'b010, 32'h100);
    env_exception_i = 2'b01;
    tick();
    env_exception_i = '0;
    release_redirect(16'h0000);
    priv_lvl_i = 1'b1; mstatus_mie_i = 1'b0;

    // Clear against a held level
    irq_i[7] = 1'b1;
    tick();
    pend_clr_i[7] = 1'b1;
    tick();
    pend_clr_i = '0;
    check("clr_vs_level", irq_pending_o[7], 1);
    irq_i = '0;
    pend_clr_i[7] = 1'b1;
    tick();
    pend_clr_i = '0;
    check("clr_released", irq_pending_o[7], 0);

    // Reset during ENTRY
    mtvec_i = 32'h100; fault_instr_i = 32'h1234; instr_exception_i = 2'b01;
    tick();
    instr_exception_i = '0;
    check("entry_before_reset", csr_we_o, 1);
    rst_i = 1'b1;
    #1;
    check("midrst_csr_we", csr_we_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_valid", redirect_valid_o, 0);
    check("midrst_mcause", mcause_o, 0);
    check("midrst_mtval", mtval_o, 0);
    check("midrst_mepc", mepc_o, 0);
    check("midrst_trap_state", trap_state_o, 0);
    check("midrst_addr", redirect_addr_o, 0);
    tick();
    rst_i = 1'b0;
    repeat (4) tick();
    check("post_rst_idle", {busy_o, csr_we_o, redirect_valid_o}, 3'b000);

    check("csr_q_empty", csr_q.size(), 0);
    check("redir_q_empty", redir_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
